zigbee_cordic_rot_iter: RTL and testbench



---
 rtl/zigbee_cordic_pkg.sv | 26 ++
 rtl/zigbee_cordic_rot_iter_if.sv | 26 ++
 rtl/zigbee_cordic_rot_stage.sv | 40 ++++
 rtl/zigbee_cordic_rot_iter.sv | 128 ++++++++++++
 tb/tb_zigbee_cordic_rot_iter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/zigbee_cordic_pkg.sv
// Shared types and helpers for the iterative rotation-mode CORDIC.
//   state_t   : controller states (IDLE, ROT, OUT)
//   atan_lsb  : micro-rotation angle T[i] in phase-word LSBs
//   sat_iq    : symmetric saturation to +/-(2^(iq_size-1)-1)
package zigbee_cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    OUT
  } state_t;

  // Binary-weighted angle table: stage 0 is 45 deg (1/8 of full scale at W=6).
  function automatic int unsigned atan_lsb(input int unsigned i, input int unsigned num_stages);
    return 32'd1 << (num_stages - 1 - i);
  endfunction

  function automatic int sat_iq(input int v, input int unsigned iq_size);
    int lim;
    lim = (1 << (iq_size - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/zigbee_cordic_rot_iter_if.sv
// Handshake bundle for zigbee_cordic_rot_iter.
//   Win/in_valid/in_ready       : phase word in (upstream -> CORDIC)
//   Iout/Qout/out_valid/out_ready : I/Q sample out (CORDIC -> downstream)
// master: the environment around the block; slave: the CORDIC itself.
interface zigbee_cordic_rot_iter_if #(
  parameter int unsigned W_SIZE  = 6,
  parameter int unsigned IQ_SIZE = 5
);
  logic [W_SIZE-1:0]         Win;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [IQ_SIZE-1:0] Iout;
  logic signed [IQ_SIZE-1:0] Qout;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output Win, in_valid, out_ready,
    input  in_ready, Iout, Qout, out_valid
  );

  modport slave (
    input  Win, in_valid, out_ready,
    output in_ready, Iout, Qout, out_valid
  );
endinterface

// File: rtl/zigbee_cordic_rot_stage.sv
// One combinational CORDIC micro-rotation, reused for every iteration.
//   i_x, i_y  : current vector (signed)
//   i_z       : residual angle (signed, phase-word LSBs)
//   i_shift   : iteration index i (shift amount and table index)
//   o_x, o_y, o_z : rotated vector and updated residual angle
module zigbee_cordic_rot_stage
  import zigbee_cordic_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned XY_W       = 6,
  parameter int unsigned W_SIZE     = 6,
  parameter int unsigned CW         = 2
) (
  input  logic signed [XY_W-1:0]   i_x,
  input  logic signed [XY_W-1:0]   i_y,
  input  logic signed [W_SIZE-1:0] i_z,
  input  logic [CW-1:0]            i_shift,
  output logic signed [XY_W-1:0]   o_x,
  output logic signed [XY_W-1:0]   o_y,
  output logic signed [W_SIZE-1:0] o_z
);
  logic signed [XY_W-1:0] w_xs;
  logic signed [XY_W-1:0] w_ys;
  logic [W_SIZE-1:0]      w_t;

  always_comb begin
    w_xs = i_x >>> i_shift;
    w_ys = i_y >>> i_shift;
    w_t  = W_SIZE'(atan_lsb(32'(i_shift), NUM_STAGES));
    if (!i_z[W_SIZE-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - $signed(w_t);
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + $signed(w_t);
    end
  end
endmodule

// File: rtl/zigbee_cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: phase word -> fixed-amplitude I/Q sample.
// One micro-rotation per clock; valid/ready on input and output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of zigbee_cordic_rot_iter_if
//                (Win/in_valid/in_ready, Iout/Qout/out_valid/out_ready)
// Build option: ZIGBEE_CORDIC_ROT_BACK2BACK_EN lets a new phase word be
// accepted on the same edge the pending result is consumed.
module zigbee_cordic_rot_iter
  import zigbee_cordic_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned IQ_SIZE    = 5,
  parameter int unsigned W_SIZE     = 6,
  parameter int          AMP        = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  zigbee_cordic_rot_iter_if.slave bus
);
  localparam int unsigned XY_W = IQ_SIZE + 1;
  localparam int unsigned CW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [XY_W-1:0]    r_x;
  logic signed [XY_W-1:0]    r_y;
  logic signed [W_SIZE-1:0]  r_z;
  logic [CW-1:0]             r_cnt;
  logic                      r_neg;
  logic signed [IQ_SIZE-1:0] r_iout;
  logic signed [IQ_SIZE-1:0] r_qout;

  logic signed [XY_W-1:0]    w_x_nxt;
  logic signed [XY_W-1:0]    w_y_nxt;
  logic signed [W_SIZE-1:0]  w_z_nxt;
  logic signed [W_SIZE-1:0]  w_z_pre;
  logic                      w_flip;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_last;
  int                        w_i_full;
  int                        w_q_full;

  zigbee_cordic_rot_stage #(
    .NUM_STAGES (NUM_STAGES),
    .XY_W       (XY_W),
    .W_SIZE     (W_SIZE),
    .CW         (CW)
  ) u_stage (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_cnt),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  // Quadrants 01/10 are folded by -180 deg (toggling the MSB) and the result
  // negated afterwards, keeping the iterations inside their +/-90 deg range.
  assign w_flip   = bus.Win[W_SIZE-1] ^ bus.Win[W_SIZE-2];
  assign w_z_pre  = $signed({bus.Win[W_SIZE-1] ^ w_flip, bus.Win[W_SIZE-2:0]});
  assign w_last   = (r_cnt == CW'(NUM_STAGES - 1));
  assign w_accept = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = ROT;
      end
      ROT: if (w_last) w_state_nxt = OUT;
      OUT: if (bus.out_ready) begin
`ifdef ZIGBEE_CORDIC_ROT_BACK2BACK_EN
        w_in_ready  = 1'b1;
        w_state_nxt = bus.in_valid ? ROT : IDLE;
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_i_full = r_neg ? -int'(w_x_nxt) : int'(w_x_nxt);
    w_q_full = r_neg ? -int'(w_y_nxt) : int'(w_y_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_iout <= '0;
      r_qout <= '0;
    end else if (w_accept) begin
      r_x   <= XY_W'(AMP);
      r_y   <= '0;
      r_z   <= w_z_pre;
      r_cnt <= '0;
      r_neg <= w_flip;
    end else if (r_state == ROT) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_z   <= w_z_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_iout <= IQ_SIZE'(sat_iq(w_i_full, IQ_SIZE));
        r_qout <= IQ_SIZE'(sat_iq(w_q_full, IQ_SIZE));
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == OUT);
  assign bus.Iout      = r_iout;
  assign bus.Qout      = r_qout;
endmodule

// File: tb/tb_zigbee_cordic_rot_iter.sv
// Directed bench for zigbee_cordic_rot_iter (default parameters).
// Expected I/Q come from a hand-computed table indexed by the folded phase.
module tb_zigbee_cordic_rot_iter;
  localparam int unsigned NS  = 4;
  localparam int unsigned IQ  = 5;
  localparam int unsigned W   = 6;
  localparam int          AMP = 9;
`ifdef ZIGBEE_CORDIC_ROT_BACK2BACK_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 6;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  zigbee_cordic_rot_iter_if #(.W_SIZE(W), .IQ_SIZE(IQ)) bus ();

  zigbee_cordic_rot_iter #(
    .NUM_STAGES (NS),
    .IQ_SIZE    (IQ),
    .W_SIZE     (W),
    .AMP        (AMP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int acc_cyc[$];

  // Folded angle z in [-16,15]; each pair (2k-16, 2k-15) shares one result.
  int exp_i_tab [16] = '{-2, 2, 6, 10, 11, 13, 15, 15, 14, 14, 13, 11, 9, 7, 3, 1};
  int exp_q_tab [16] = '{-14, -14, -13, -11, -9, -7, -4, 0, 1, 3, 7, 9, 11, 13, 14, 14};

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    bit acc;
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  endtask

  function automatic void ref_iq(input int w, output int ei, output int eq);
    int  z;
    bit  neg;
    neg = (w >= 16) && (w < 48);
    z   = neg ? w - 32 : ((w >= 48) ? w - 64 : w);
    ei  = exp_i_tab[(z + 16) / 2];
    eq  = exp_q_tab[(z + 16) / 2];
    if (neg) begin
      ei = -ei;
      eq = -eq;
    end
  endfunction

  // One transfer with out_ready held high; checks accept, latency, result.
  task automatic run_one(input int w, input string tag);
    int ei, eq, acc0, lat;
    ref_iq(w, ei, eq);
    bus.Win       = 6'(w);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    acc0 = n_acc;
    for (int k = 0; k < 20 && n_acc == acc0; k++) tick();
    bus.in_valid = 1'b0;
    check({tag, " accepted"}, n_acc - acc0, 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " I"}, int'(bus.Iout), ei);
    check({tag, " Q"}, int'(bus.Qout), eq);
    tick();
    check({tag, " out_valid clears"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0, rel, lat, ei, eq;
    rst_n         = 1'b0;
    bus.Win       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst in_ready", int'(bus.in_ready), 1);
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst Iout", int'(bus.Iout), 0);
    check("rst Qout", int'(bus.Qout), 0);
    rst_n = 1'b1;
    tick();

    // Directed points including quadrant boundaries.
    run_one(0, "w0");
    run_one(16, "w16");
    run_one(32, "w32");
    run_one(15, "w15");
    run_one(47, "w47");
    run_one(48, "w48");

    // Asynchronous reset in the middle of the rotation.
    bus.Win      = 6'd16;
    bus.in_valid = 1'b1;
    acc0 = n_acc;
    for (int k = 0; k < 20 && n_acc == acc0; k++) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrot rst out_valid", int'(bus.out_valid), 0);
    check("midrot rst Iout", int'(bus.Iout), 0);
    check("midrot rst Qout", int'(bus.Qout), 0);
    check("midrot rst in_ready", int'(bus.in_ready), 1);
    tick();
    rst_n = 1'b1;
    check("post rst in_ready", int'(bus.in_ready), 1);
    repeat (6) tick();
    check("post rst no partial result", int'(bus.out_valid), 0);
    run_one(5, "w5 after rst");

    // Backpressure: result held, pending input not taken, one transfer on release.
    bus.Win       = 6'd32;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    acc0 = n_acc;
    for (int k = 0; k < 20 && n_acc == acc0; k++) tick();
    bus.Win = 6'd8;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp latency", lat, 4);
    acc0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp hold%0d out_valid", k), int'(bus.out_valid), 1);
      check($sformatf("bp hold%0d I", k), int'(bus.Iout), -14);
      check($sformatf("bp hold%0d Q", k), int'(bus.Qout), -1);
      check($sformatf("bp hold%0d in_ready", k), int'(bus.in_ready), 0);
    end
    check("bp pending not accepted", n_acc - acc0, 0);
    bus.out_ready = 1'b1;
    tick();
    rel = cyc;
    check("bp release out_valid", int'(bus.out_valid), 0);
    for (int k = 0; k < 5 && n_acc == acc0; k++) tick();
    bus.in_valid = 1'b0;
    check("bp single accept", n_acc - acc0, 1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp next result edges", cyc - rel, SPACING - 1);
    ref_iq(8, ei, eq);
    check("bp next I", int'(bus.Iout), ei);
    check("bp next Q", int'(bus.Qout), eq);
    tick();
    check("bp next consumed", int'(bus.out_valid), 0);

    // Sustained input with a free consumer: accept spacing.
    acc_cyc.delete();
    bus.Win       = 6'd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) begin
        check("b2b I", int'(bus.Iout), 14);
        check("b2b Q", int'(bus.Qout), 1);
      end
    end
    bus.in_valid = 1'b0;
    check("b2b enough accepts", int'(acc_cyc.size() >= 5), 1);
    for (int k = 1; k < 5 && k < acc_cyc.size(); k++)
      check($sformatf("b2b spacing%0d", k), acc_cyc[k] - acc_cyc[k-1], SPACING);
    lat = 0;
    while (bus.in_ready == 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    tick();

    // Full sweep of the phase word.
    for (int w = 0; w < 64; w++) run_one(w, $sformatf("sweep w=%0d", w));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
